halt_checker: RTL and testbench
===============================

# halt_checker

Parametrised self-check and report unit for the pipelined processor. It counts cycles from reset until the write-back stage shows the halt opcode, then snapshots NCH observed architectural values (registers and data-memory words). It compares each value against its expected constant and streams one ASCII pass/fail character per channel plus a summary character to the OLED display write port through a valid/ready handshake. It generalises the fixed four-signal halt comparison in the processor top to any channel count and width, adds back-pressure and a clear, and has an optional timeout.

## Interface
- NCH, 4, number of checked channels (1..63)
- DW, 32, width of each observed/expected value
- CW, 32, cycle counter width
- HALT_OP, 6'b111111, opcode that marks end of program in write-back
- TIMEOUT, 1000000, cycle limit before forced check (used only with the timeout macro)

- clk  in  1  system clock, rising edge
- rstd  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear; returns to RUN with counter zeroed
- op_w  in  6  opcode currently in write-back stage
- obs  in  NCH*DW  observed values, channel i at [i*DW +: DW]
- exp  in  NCH*DW  expected values, same packing
- cyc_count  out  CW  cycles counted before halt (frozen after halt)
- pass_mask  out  NCH  bit i = channel i matched
- all_pass  out  1  &pass_mask, valid when done=1
- done  out  1  report fully delivered
- oled_we  out  1  write beat valid
- oled_addr  out  6  display character slot
- oled_data  out  8  ASCII character
- oled_rdy  in  1  display accepts beat this cycle

## Operation
- States: RUN -> CHECK -> EMIT -> DONE.
- RUN: cyc_count += 1 each cycle with op_w != HALT_OP; saturates at all-ones, no wrap. On the first edge with op_w == HALT_OP: latch obs into a snapshot register, freeze cyc_count, go to CHECK.
- CHECK (1 cycle): pass_mask[i] <= (snap[i] == exp[i]); go to EMIT with beat index 0.
- EMIT: beats 0..NCH-1 write addr=i, data=8'h2B '+' when pass_mask[i] is set, else 8'h2D '-'. Beat NCH writes addr=NCH, data=8'h50 'P' when all_pass, else 8'h46 'F'. A beat is consumed at an edge where oled_we & oled_rdy; addr/data are held stable otherwise. After the summary is consumed, go to DONE.
- DONE: done=1, outputs hold; halt opcodes are ignored.
- HALT_OP seen in CHECK/EMIT/DONE: ignored.
- clr (any state): next edge → RUN, cyc_count=0, pass_mask=0, done=0, oled_we=0, oled_data=8'h2C. An aborted beat is dropped, not completed.
- clr and halt in the same cycle: clr wins; halt is not captured.
- exp is sampled in CHECK only; obs is sampled only at the halt edge.

## Timing
- Reset values: cyc_count=0, pass_mask=0, all_pass=0, done=0, oled_we=0, oled_addr=0, oled_data=8'h2C ','. State=RUN.
- Halt at edge T: CHECK during cycle T..T+1, oled_we=1 from T+1 edge with beat 0.
- With oled_rdy held high: one beat per cycle, NCH+1 beats. done rises at edge T+1+(NCH+1).
- Registered outputs only; no combinational path from oled_rdy to oled_we/addr/data.
- Async reset mid-EMIT drops oled_we immediately (asynchronous assertion).

## Configuration
- HALT_CHECKER_TIMEOUT_EN defined: in RUN, when cyc_count reaches TIMEOUT without halt, behave as if halt at that edge. Also set a sticky timed_out flag; the summary beat then writes 8'h54 'T' regardless of pass_mask. Channel beats are unchanged.
- Undefined: no timeout logic; RUN waits for halt indefinitely, and the summary is only 'P'/'F'.

## Structure
- Package halt_checker_pkg: state enum (RUN, CHECK, EMIT, DONE), ASCII constants (CH_PASS 8'h2B, CH_FAIL 8'h2D, CH_IDLE 8'h2C, CH_SUM_P 8'h50, CH_SUM_F 8'h46, CH_SUM_T 8'h54), default HALT_OP.
- Sub-module halt_report_tx: beat index counter, valid/ready hold logic, and character mux from pass_mask/all_pass/timed_out; top holds FSM, counter, snapshot, compare.

## Test plan
- NCH=4, all obs==exp, halt after 57 cycles, oled_rdy=1 → cyc_count=57, beats addr0..3 data 8'h2B, addr4 8'h50, done at halt+6 edges.
- Channel 2 mismatched (obs=97, exp=98) → pass_mask=4'b1011, beat addr2 8'h2D, summary 8'h46, all_pass=0.
- oled_rdy toggles 1/0 every cycle → each beat held until accepted, no duplicates or skips, 5 accepted beats total.
- obs changes after halt, and a second HALT_OP appears during EMIT → report reflects the halt-edge snapshot; cyc_count unchanged.
- clr asserted during beat 2, then a new halt 10 cycles later → oled_we drops, oled_data=8'h2C, cyc_count restarts, full 5-beat report follows.
- With HALT_CHECKER_TIMEOUT_EN and TIMEOUT=20, no halt → forced check at cycle 20; summary 8'h54.

Source files
------------

// File: rtl/halt_checker_pkg.sv
// Shared constants for the halt self-check unit: FSM state codes, report characters and the
// default end-of-program opcode.
package halt_checker_pkg;

  localparam logic [1:0] StRun   = 2'd0;
  localparam logic [1:0] StCheck = 2'd1;
  localparam logic [1:0] StEmit  = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  localparam logic [7:0] CH_PASS  = 8'h2B;  // '+'
  localparam logic [7:0] CH_FAIL  = 8'h2D;  // '-'
  localparam logic [7:0] CH_IDLE  = 8'h2C;  // ','
  localparam logic [7:0] CH_SUM_P = 8'h50;  // 'P'
  localparam logic [7:0] CH_SUM_F = 8'h46;  // 'F'
  localparam logic [7:0] CH_SUM_T = 8'h54;  // 'T'

  localparam logic [5:0] HALT_OP_DEFAULT = 6'b111111;

endpackage

// File: rtl/halt_report_tx.sv
// Streams one pass/fail character per channel and a summary character to the display port
// through a registered valid/ready handshake.
module halt_report_tx
  import halt_checker_pkg::*;
#(
  parameter int unsigned NCH = 4
) (
  input  logic           clk_i,
  input  logic           rstd_ni,
  input  logic           clr_i,
  input  logic           start_i,
  input  logic [NCH-1:0] pass_mask_i,
  input  logic           timed_out_i,
  input  logic           oled_rdy_i,
  output logic           oled_we_o,
  output logic [5:0]     oled_addr_o,
  output logic [7:0]     oled_data_o,
  output logic           last_o
);

  localparam logic [5:0] SumIdx = 6'(NCH);

  logic       we_q, we_d;
  logic [5:0] addr_q, addr_d;
  logic [7:0] data_q, data_d;
  logic       accept;

  function automatic logic [7:0] beat_char(logic [5:0] idx, logic [NCH-1:0] mask, logic to);
    logic [NCH-1:0] sh;
    sh = mask >> idx;
    if (idx == SumIdx) begin
      return to ? CH_SUM_T : ((&mask) ? CH_SUM_P : CH_SUM_F);
    end
    return sh[0] ? CH_PASS : CH_FAIL;
  endfunction

  // The beat index doubles as the display address.
  assign accept = we_q & oled_rdy_i;
  assign last_o = accept && (addr_q == SumIdx);

  always_comb begin
    we_d   = we_q;
    addr_d = addr_q;
    data_d = data_q;
    if (clr_i) begin
      we_d   = 1'b0;
      addr_d = 6'd0;
      data_d = CH_IDLE;
    end else if (start_i) begin
      we_d   = 1'b1;
      addr_d = 6'd0;
      data_d = beat_char(6'd0, pass_mask_i, timed_out_i);
    end else if (accept) begin
      if (addr_q == SumIdx) begin
        we_d = 1'b0;
      end else begin
        addr_d = addr_q + 6'd1;
        data_d = beat_char(addr_q + 6'd1, pass_mask_i, timed_out_i);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstd_ni) begin
    if (!rstd_ni) begin
      we_q   <= 1'b0;
      addr_q <= 6'd0;
      data_q <= CH_IDLE;
    end else begin
      we_q   <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
    end
  end

  assign oled_we_o   = we_q;
  assign oled_addr_o = addr_q;
  assign oled_data_o = data_q;

endmodule

// File: rtl/halt_checker.sv
// Counts cycles until the halt opcode reaches write-back, snapshots and checks NCH values and
// reports them to the display. Optional timeout: define HALT_CHECKER_TIMEOUT_EN.
module halt_checker
  import halt_checker_pkg::*;
#(
  parameter int unsigned NCH     = 4,
  parameter int unsigned DW      = 32,
  parameter int unsigned CW      = 32,
  parameter logic [5:0]  HALT_OP = HALT_OP_DEFAULT,
  parameter int unsigned TIMEOUT = 1000000
) (
  input  logic              clk_i,
  input  logic              rstd_ni,
  input  logic              clr_i,
  input  logic [5:0]        op_w_i,
  input  logic [NCH*DW-1:0] obs_i,
  input  logic [NCH*DW-1:0] exp_i,
  output logic [CW-1:0]     cyc_count_o,
  output logic [NCH-1:0]    pass_mask_o,
  output logic              all_pass_o,
  output logic              done_o,
  output logic              oled_we_o,
  output logic [5:0]        oled_addr_o,
  output logic [7:0]        oled_data_o,
  input  logic              oled_rdy_i
);

  logic [1:0]        state_q, state_d;
  logic [CW-1:0]     cyc_q, cyc_d;
  logic [NCH*DW-1:0] snap_q, snap_d;
  logic [NCH-1:0]    pass_q, pass_d;
  logic              done_q, done_d;
  logic              timed_out_q, timed_out_d;
  logic              timeout_hit;
  logic              tx_last;

`ifdef HALT_CHECKER_TIMEOUT_EN
  assign timeout_hit = (cyc_q >= CW'(TIMEOUT));
`else
  assign timeout_hit = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    snap_d      = snap_q;
    pass_d      = pass_q;
    done_d      = done_q;
    timed_out_d = timed_out_q;
    if (clr_i) begin
      state_d     = StRun;
      cyc_d       = '0;
      pass_d      = '0;
      done_d      = 1'b0;
      timed_out_d = 1'b0;
    end else begin
      case (state_q)
        StRun: begin
          if ((op_w_i == HALT_OP) || timeout_hit) begin
            snap_d      = obs_i;
            state_d     = StCheck;
            timed_out_d = timeout_hit && (op_w_i != HALT_OP);
          end else if (cyc_q != {CW{1'b1}}) begin
            cyc_d = cyc_q + 1'b1;
          end
        end
        StCheck: begin
          for (int i = 0; i < int'(NCH); i++) begin
            pass_d[i] = (snap_q[i*DW +: DW] == exp_i[i*DW +: DW]);
          end
          state_d = StEmit;
        end
        StEmit: begin
          if (tx_last) begin
            state_d = StDone;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rstd_ni) begin
    if (!rstd_ni) begin
      state_q     <= StRun;
      cyc_q       <= '0;
      snap_q      <= '0;
      pass_q      <= '0;
      done_q      <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      snap_q      <= snap_d;
      pass_q      <= pass_d;
      done_q      <= done_d;
      timed_out_q <= timed_out_d;
    end
  end

  // pass_d carries the fresh compare result on the CHECK edge so beat 0 is correct.
  halt_report_tx #(
    .NCH (NCH)
  ) u_tx (
    .clk_i       (clk_i),
    .rstd_ni     (rstd_ni),
    .clr_i       (clr_i),
    .start_i     (state_q == StCheck),
    .pass_mask_i (pass_d),
    .timed_out_i (timed_out_q),
    .oled_rdy_i  (oled_rdy_i),
    .oled_we_o   (oled_we_o),
    .oled_addr_o (oled_addr_o),
    .oled_data_o (oled_data_o),
    .last_o      (tx_last)
  );

  assign cyc_count_o = cyc_q;
  assign pass_mask_o = pass_q;
  assign all_pass_o  = &pass_q;
  assign done_o      = done_q;

endmodule

// File: tb/tb_halt_checker.sv
// Randomised self-checking bench for halt_checker against a per-run expected-report model.
module tb_halt_checker;

  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int CW  = 32;
  localparam logic [5:0] HALT = 6'b111111;

  logic              clk = 1'b0;
  logic              rstd_n = 1'b0;
  logic              clr = 1'b0;
  logic [5:0]        op_w = 6'd0;
  logic [NCH*DW-1:0] obs = '0;
  logic [NCH*DW-1:0] exp_w = '0;
  logic              oled_rdy = 1'b0;
  logic [CW-1:0]     cyc_count;
  logic [NCH-1:0]    pass_mask;
  logic              all_pass, done, oled_we;
  logic [5:0]        oled_addr;
  logic [7:0]        oled_data;

  int n_cmp = 0;
  int n_bad = 0;
  int edge_cnt = 0;
  logic [13:0] got_q[$];

  halt_checker #(
    .NCH (NCH),
    .DW  (DW),
    .CW  (CW)
  ) u_dut (
    .clk_i       (clk),
    .rstd_ni     (rstd_n),
    .clr_i       (clr),
    .op_w_i      (op_w),
    .obs_i       (obs),
    .exp_i       (exp_w),
    .cyc_count_o (cyc_count),
    .pass_mask_o (pass_mask),
    .all_pass_o  (all_pass),
    .done_o      (done),
    .oled_we_o   (oled_we),
    .oled_addr_o (oled_addr),
    .oled_data_o (oled_data),
    .oled_rdy_i  (oled_rdy)
  );

`ifdef HALT_CHECKER_TIMEOUT_EN
  logic [CW-1:0]  to_cyc;
  logic [NCH-1:0] to_mask;
  logic           to_all, to_done, to_we;
  logic [5:0]     to_addr;
  logic [7:0]     to_data;

  halt_checker #(
    .NCH     (NCH),
    .DW      (DW),
    .CW      (CW),
    .TIMEOUT (20)
  ) u_dut_to (
    .clk_i       (clk),
    .rstd_ni     (rstd_n),
    .clr_i       (clr),
    .op_w_i      (op_w),
    .obs_i       (obs),
    .exp_i       (exp_w),
    .cyc_count_o (to_cyc),
    .pass_mask_o (to_mask),
    .all_pass_o  (to_all),
    .done_o      (to_done),
    .oled_we_o   (to_we),
    .oled_addr_o (to_addr),
    .oled_data_o (to_data),
    .oled_rdy_i  (oled_rdy)
  );
`endif

  always #5 clk = ~clk;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  always @(posedge clk) begin
    if (rstd_n && oled_we && oled_rdy) got_q.push_back({oled_addr, oled_data});
  end

  function automatic logic [5:0] rnd_op();
    logic [5:0] o;
    o = 6'($urandom_range(0, 62));
    return o;
  endfunction

  function automatic logic [NCH*DW-1:0] rnd_vec();
    logic [NCH*DW-1:0] v;
    for (int i = 0; i < NCH; i++) v[i*DW +: DW] = $urandom;
    return v;
  endfunction

  // rmode: 0 = ready always high, 1 = toggle, 2 = random.
  task automatic run_report(input int pre, input logic [NCH*DW-1:0] ov,
                            input logic [NCH*DW-1:0] ev, input int rmode, input bit churn,
                            input bit do_clr, input string name);
    logic [NCH-1:0] m;
    logic [13:0]    expb[$];
    int             t_halt, waited, sz;
    m = '0;
    for (int i = 0; i < NCH; i++) begin
      m[i] = (ov[i*DW +: DW] == ev[i*DW +: DW]);
      expb.push_back({6'(i), m[i] ? 8'h2B : 8'h2D});
    end
    expb.push_back({6'(NCH), (&m) ? 8'h50 : 8'h46});

    if (do_clr) begin
      @(negedge clk);
      clr = 1'b1;
      oled_rdy = 1'b0;
      op_w = HALT;
      @(negedge clk);
      clr = 1'b0;
    end
    got_q.delete();
    repeat (pre) begin
      op_w = rnd_op();
      obs = rnd_vec();
      @(negedge clk);
    end
    op_w = HALT;
    obs = ov;
    exp_w = ev;
    @(negedge clk);
    t_halt = edge_cnt;
    op_w = churn ? HALT : rnd_op();
    if (churn) obs = rnd_vec();
    waited = 0;
    oled_rdy = (rmode == 1) ? 1'b0 : 1'b1;
    while (!done && waited < 300) begin
      case (rmode)
        0: oled_rdy = 1'b1;
        1: oled_rdy = ~oled_rdy;
        default: oled_rdy = 1'($urandom_range(0, 1));
      endcase
      @(negedge clk);
      waited++;
      if (churn) begin
        exp_w = rnd_vec();
        obs = rnd_vec();
        op_w = (waited % 2 == 1) ? HALT : rnd_op();
      end
    end

    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL %s done: got %b want 1 (timed out after %0d cycles)", name, done, waited);
    end
    if (rmode == 0) begin
      n_cmp++;
      if (edge_cnt - t_halt !== NCH + 2) begin
        n_bad++;
        $display("FAIL %s done_latency: got %0d want %0d", name, edge_cnt - t_halt, NCH + 2);
      end
    end
    // Extra cycles with halt present: everything must hold.
    op_w = HALT;
    oled_rdy = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (cyc_count !== CW'(pre)) begin
      n_bad++;
      $display("FAIL %s cyc_count: got %0d want %0d", name, cyc_count, pre);
    end
    n_cmp++;
    if (pass_mask !== m) begin
      n_bad++;
      $display("FAIL %s pass_mask: got %b want %b", name, pass_mask, m);
    end
    n_cmp++;
    if (all_pass !== (&m)) begin
      n_bad++;
      $display("FAIL %s all_pass: got %b want %b", name, all_pass, &m);
    end
    n_cmp++;
    if (done !== 1'b1 || oled_we !== 1'b0) begin
      n_bad++;
      $display("FAIL %s hold: got done=%b we=%b want done=1 we=0", name, done, oled_we);
    end
    sz = got_q.size();
    n_cmp++;
    if (sz !== NCH + 1) begin
      n_bad++;
      $display("FAIL %s beat_count: got %0d want %0d", name, sz, NCH + 1);
    end
    for (int i = 0; i < NCH + 1; i++) begin
      n_cmp++;
      if (i >= sz) begin
        n_bad++;
        $display("FAIL %s beat%0d: got none want %h", name, i, expb[i]);
      end else if (got_q[i] !== expb[i]) begin
        n_bad++;
        $display("FAIL %s beat%0d: got addr=%0d data=%h want addr=%0d data=%h", name, i,
                 got_q[i][13:8], got_q[i][7:0], expb[i][13:8], expb[i][7:0]);
      end
    end
  endtask

  task automatic test_reset();
    rstd_n = 1'b0;
    op_w = HALT;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({cyc_count, pass_mask, all_pass, done, oled_we, oled_addr, oled_data} !==
        {32'd0, 4'd0, 1'b0, 1'b0, 1'b0, 6'd0, 8'h2C}) begin
      n_bad++;
      $display("FAIL reset: got cyc=%0d mask=%b all=%b done=%b we=%b addr=%0d data=%h want 0/0/0/0/0/0/2c",
               cyc_count, pass_mask, all_pass, done, oled_we, oled_addr, oled_data);
    end
    op_w = 6'd0;
    rstd_n = 1'b1;
  endtask

  task automatic test_all_pass();
    logic [NCH*DW-1:0] v;
    v = rnd_vec();
    run_report(57, v, v, 0, 1'b0, 1'b1, "all_pass");
  endtask

  task automatic test_mismatch();
    logic [NCH*DW-1:0] ov, ev;
    ov = rnd_vec();
    ev = ov;
    ov[2*DW +: DW] = 32'd97;
    ev[2*DW +: DW] = 32'd98;
    run_report(13, ov, ev, 0, 1'b0, 1'b1, "mismatch");
  endtask

  task automatic test_back_to_back();
    logic [NCH*DW-1:0] v;
    v = rnd_vec();
    run_report(8, v, v, 1, 1'b0, 1'b1, "backpressure");
  endtask

  task automatic test_snapshot();
    logic [NCH*DW-1:0] ov, ev;
    ov = rnd_vec();
    ev = ov;
    ev[0 +: DW] = ~ov[0 +: DW];
    run_report(21, ov, ev, 2, 1'b1, 1'b1, "snapshot");
  endtask

  task automatic test_clear();
    logic [NCH*DW-1:0] v;
    int waited;
    v = rnd_vec();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (5) begin
      op_w = rnd_op();
      @(negedge clk);
    end
    op_w = HALT;
    obs = v;
    exp_w = v;
    oled_rdy = 1'b1;
    @(negedge clk);
    op_w = rnd_op();
    waited = 0;
    while (!(oled_we && oled_addr == 6'd2) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if (!(oled_we && oled_addr == 6'd2)) begin
      n_bad++;
      $display("FAIL clear_reach_beat2: got we=%b addr=%0d want 1/2", oled_we, oled_addr);
    end
    clr = 1'b1;
    op_w = HALT;
    @(negedge clk);
    clr = 1'b0;
    n_cmp++;
    if ({oled_we, oled_data, cyc_count, pass_mask, done} !== {1'b0, 8'h2C, 32'd0, 4'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL clear_state: got we=%b data=%h cyc=%0d mask=%b done=%b want 0/2c/0/0/0",
               oled_we, oled_data, cyc_count, pass_mask, done);
    end
    run_report(10, v, v, 0, 1'b0, 1'b0, "after_clear");
  endtask

  task automatic test_random();
    logic [NCH*DW-1:0] ov, ev;
    for (int k = 0; k < 4; k++) begin
      ov = rnd_vec();
      ev = ov;
      for (int i = 0; i < NCH; i++) begin
        if ($urandom_range(0, 1) == 1) ev[i*DW +: DW] = ov[i*DW +: DW] ^ (32'd1 << $urandom_range(0, 31));
      end
      run_report(int'($urandom_range(0, 30)), ov, ev, 2, 1'b0, 1'b1, $sformatf("random%0d", k));
    end
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    clr = 1'b1;
    oled_rdy = 1'b0;
    @(negedge clk);
    clr = 1'b0;
    op_w = HALT;
    @(negedge clk);
    op_w = 6'd0;
    @(negedge clk);
    n_cmp++;
    if (oled_we !== 1'b1) begin
      n_bad++;
      $display("FAIL async_pre: got we=%b want 1", oled_we);
    end
    #2 rstd_n = 1'b0;
    #1;
    n_cmp++;
    if ({oled_we, oled_addr, oled_data, done} !== {1'b0, 6'd0, 8'h2C, 1'b0}) begin
      n_bad++;
      $display("FAIL async_reset: got we=%b addr=%0d data=%h done=%b want 0/0/2c/0",
               oled_we, oled_addr, oled_data, done);
    end
    @(negedge clk);
    rstd_n = 1'b1;
  endtask

`ifdef HALT_CHECKER_TIMEOUT_EN
  task automatic test_timeout();
    logic [NCH*DW-1:0] v;
    int waited;
    v = rnd_vec();
    obs = v;
    exp_w = v;
    oled_rdy = 1'b1;
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    waited = 0;
    while (!to_done && waited < 100) begin
      op_w = rnd_op();
      @(negedge clk);
      waited++;
    end
    n_cmp++;
    if ({to_done, to_cyc, to_mask, to_addr, to_data} !== {1'b1, 32'd20, 4'hF, 6'(NCH), 8'h54}) begin
      n_bad++;
      $display("FAIL timeout: got done=%b cyc=%0d mask=%b addr=%0d data=%h want 1/20/1111/%0d/54",
               to_done, to_cyc, to_mask, to_addr, to_data, NCH);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_all_pass();
    test_mismatch();
    test_back_to_back();
    test_snapshot();
    test_clear();
    test_random();
    test_async_reset();
`ifdef HALT_CHECKER_TIMEOUT_EN
    test_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
